// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from a first-word-fall-through FIFO and
// frames them as start / 8 data bits (LSB first) / optional parity / stop bit(s).
// Back-to-back frames are sent with no idle gap when the FIFO stays non-empty.
module uart_tx_serializer #(
  parameter int unsigned BAUD_DIV   = 868,  // clk cycles per bit, >= 2
  parameter int unsigned PARITY_EN  = 0,    // 1 = parity bit after D7
  parameter int unsigned PARITY_ODD = 0,    // 0 = even, 1 = odd
  parameter int unsigned STOP_BITS  = 1     // 1 or 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;   // data bit index, reused as stop-bit index
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;           // parity bit computed when the byte is latched
  logic             tx_q, tx_d;

  logic bit_end;
  logic last_stop;
  logic pop;

  assign bit_end   = (cnt_q == CNT_W'(BAUD_DIV - 1));
  assign last_stop = (state_q == S_STOP) && bit_end && (bit_idx_q == 3'(STOP_BITS - 1));

  // A new byte is taken either from idle or on the very last stop-bit cycle.
  assign pop = !fifo_empty && ((state_q == S_IDLE) || last_stop);

  // The strobe is masked while reset is held so the FIFO never loses a byte
  // to a pop that the serializer is not going to act on.
  assign fifo_rd = pop && reset_n;
  assign busy    = (state_q != S_IDLE) || fifo_rd;
  assign tx_done = last_stop;
  assign tx      = tx_q;

  // Next-state, counters and shifter; the line level is derived from the next state.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tx_d      = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pop) begin
          state_d   = S_START;
          shreg_d   = fifo_data;
          par_d     = (^fifo_data) ^ (PARITY_ODD != 0);
          bit_idx_d = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            bit_idx_d = '0;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
        end
      end
      S_STOP: begin
        if (last_stop) begin
          if (pop) begin
            state_d   = S_START;
            shreg_d   = fifo_data;
            par_d     = (^fifo_data) ^ (PARITY_ODD != 0);
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, shifter and the registered tx line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the shift register is cleared on reset too; an abandoned frame
      // must not leave a stale byte behind.
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: four instances with BAUD_DIV=4
//   unit 0: no parity, 1 stop     unit 1: even parity, 1 stop
//   unit 2: odd parity, 1 stop    unit 3: no parity, 2 stop
// Expected frames are hand-written bit strings, first transmitted bit on the left.
module tb_uart_tx_serializer;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] fd [4];
  logic [3:0] fe;
  logic [3:0] rd, tx, busy, done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.BAUD_DIV(B), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
    .clk(clk), .reset_n(reset_n), .fifo_data(fd[0]), .fifo_empty(fe[0]),
    .fifo_rd(rd[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));
  uart_tx_serializer #(.BAUD_DIV(B), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .reset_n(reset_n), .fifo_data(fd[1]), .fifo_empty(fe[1]),
    .fifo_rd(rd[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));
  uart_tx_serializer #(.BAUD_DIV(B), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset_n(reset_n), .fifo_data(fd[2]), .fifo_empty(fe[2]),
    .fifo_rd(rd[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));
  uart_tx_serializer #(.BAUD_DIV(B), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .reset_n(reset_n), .fifo_data(fd[3]), .fifo_empty(fe[3]),
    .fifo_rd(rd[3]), .tx(tx[3]), .busy(busy[3]), .tx_done(done[3]));

  typedef struct {
    int          unit;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] bits;    // bit [nbits-1] goes out first
    bit          wiggle;  // scramble FIFO inputs mid-frame
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a byte on an idle unit and check the combinational pop strobe.
  task automatic pop(input int u, input logic [7:0] data);
    @(negedge clk);
    fd[u] = data;
    fe[u] = 1'b0;
    #1;
    check($sformatf("u%0d pop rd", u), 32'(rd[u]), 32'd1);
    check($sformatf("u%0d pop busy", u), 32'(busy[u]), 32'd1);
    check($sformatf("u%0d pop tx", u), 32'(tx[u]), 32'd1);
  endtask

  // Follow one frame cycle by cycle after its pop. On the final cycle the FIFO
  // inputs become last_fe/last_fd, so a pop there is expected iff last_fe=0.
  task automatic play(input int u, input int nbits, input logic [11:0] bits,
                      input bit wiggle, input logic last_fe, input logic [7:0] last_fd);
    int total;
    total = nbits * B;
    for (int cyc = 1; cyc <= total; cyc++) begin
      @(negedge clk);
      if (cyc == total) begin
        fe[u] = last_fe;
        fd[u] = last_fd;
      end else if (wiggle) begin
        fe[u] = 1'($urandom);
        fd[u] = 8'($urandom);
      end else begin
        fe[u] = 1'b1;
      end
      #1;
      check($sformatf("u%0d c%0d tx", u, cyc), 32'(tx[u]), 32'(bits[nbits - 1 - (cyc - 1) / B]));
      check($sformatf("u%0d c%0d tx_done", u, cyc), 32'(done[u]), 32'(cyc == total));
      check($sformatf("u%0d c%0d fifo_rd", u, cyc), 32'(rd[u]), 32'(cyc == total && !last_fe));
      check($sformatf("u%0d c%0d busy", u, cyc), 32'(busy[u]), 32'd1);
    end
  endtask

  task automatic idle_check(input int u);
    @(negedge clk);
    fe[u] = 1'b1;
    #1;
    check($sformatf("u%0d idle tx", u), 32'(tx[u]), 32'd1);
    check($sformatf("u%0d idle busy", u), 32'(busy[u]), 32'd0);
    check($sformatf("u%0d idle fifo_rd", u), 32'(rd[u]), 32'd0);
    check($sformatf("u%0d idle tx_done", u), 32'(done[u]), 32'd0);
  endtask

  initial begin
    //           unit data   nbits frame (first bit left)  wiggle
    vecs[0] = '{0, 8'hA5, 10, 12'b0101001011,   1'b0};
    vecs[1] = '{0, 8'h3C, 10, 12'b0001111001,   1'b1};
    vecs[2] = '{1, 8'h07, 11, 12'b01110000011,  1'b0};  // even parity -> 1
    vecs[3] = '{2, 8'h07, 11, 12'b01110000001,  1'b0};  // odd parity  -> 0
    vecs[4] = '{1, 8'h00, 11, 12'b00000000001,  1'b1};  // even parity -> 0
    vecs[5] = '{2, 8'hFF, 11, 12'b01111111111,  1'b1};  // odd parity  -> 1

    reset_n = 1'b0;
    fe      = 4'hF;
    for (int i = 0; i < 4; i++) fd[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle with an empty FIFO: line high, no pops, not busy.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("idle%0d tx", c), 32'(tx), 32'hF);
      check($sformatf("idle%0d fifo_rd", c), 32'(rd), 32'h0);
      check($sformatf("idle%0d busy", c), 32'(busy), 32'h0);
    end

    // Single frames from the table.
    for (int v = 0; v < 6; v++) begin
      pop(vecs[v].unit, vecs[v].data);
      play(vecs[v].unit, vecs[v].nbits, vecs[v].bits, vecs[v].wiggle, 1'b1, 8'h00);
      idle_check(vecs[v].unit);
    end

    // Back-to-back frames with two stop bits: the second pop lands on the
    // first tx_done and the next start bit follows immediately.
    pop(3, 8'h55);
    play(3, 11, 12'b01010101011, 1'b0, 1'b0, 8'h0F);
    play(3, 11, 12'b01111000011, 1'b0, 1'b1, 8'h00);
    idle_check(3);

    // Reset in the middle of data bit 3 of 0xA5 (a 0 on the line).
    pop(0, 8'hA5);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      fe[0] = 1'b1;
    end
    #1;
    check("rst pre tx", 32'(tx[0]), 32'd0);
    fe[0] = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("rst tx", 32'(tx[0]), 32'd1);
    check("rst busy", 32'(busy[0]), 32'd0);
    check("rst fifo_rd", 32'(rd[0]), 32'd0);
    check("rst tx_done", 32'(done[0]), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst hold tx", 32'(tx[0]), 32'd1);
    check("rst hold fifo_rd", 32'(rd[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst release fifo_rd", 32'(rd[0]), 32'd1);
    check("rst release busy", 32'(busy[0]), 32'd1);
    play(0, 10, 12'b0101001011, 1'b0, 1'b1, 8'h00);
    idle_check(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
